// File: rtl/dice_display.sv
// dice_display: latches a dice result, plays a spinning-segment animation, then shows it on a muxed 2-digit 7-seg.
// Optional DICE_DISPLAY_BLINK_EN: result blinks 3 times on entering SHOW before holding steady.
module dice_display #(
    parameter int MUX_CYCLES  = 1000,
    parameter int STEP_CYCLES = 50000,
    parameter int ANIM_STEPS  = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       value_valid,
    input  logic [4:0] dice_value,
    input  logic       twty_mode,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SPIN, SHOW} state_t;
    localparam int MW = $clog2(MUX_CYCLES);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam int AW = $clog2(ANIM_STEPS + 1);
    localparam logic [MW-1:0] MUX_LAST  = MW'(MUX_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_STEPS - 1);

    state_t          state_q, state_d;
    logic [MW-1:0]   mux_q, mux_d;
    logic [SW-1:0]   step_q, step_d;
    logic [AW-1:0]   n_q, n_d;
    logic [2:0]      k_q, k_d;
    logic [4:0]      val_q, val_d;
    logic            mode_q, mode_d;
    logic [1:0]      dsel_q, dsel_d;
    logic [6:0]      seg_q, seg_d;
    logic            busy_q;
    logic            step_wrap, blank_d;

    function automatic logic [6:0] digit7(input logic [3:0] d);
        case (d)
            4'd0: digit7 = 7'h3F;
            4'd1: digit7 = 7'h06;
            4'd2: digit7 = 7'h5B;
            4'd3: digit7 = 7'h4F;
            4'd4: digit7 = 7'h66;
            4'd5: digit7 = 7'h6D;
            4'd6: digit7 = 7'h7D;
            4'd7: digit7 = 7'h07;
            4'd8: digit7 = 7'h7F;
            4'd9: digit7 = 7'h6F;
            default: digit7 = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] result7(input logic [4:0] v, input logic mode, input logic tens_sel);
        logic [1:0] tens;
        logic [4:0] ones;
        tens = (v >= 5'd20) ? 2'd2 : (v >= 5'd10) ? 2'd1 : 2'd0;
        ones = v - 5'd10 * {3'b000, tens};
        if (v == 5'd0 || v > (mode ? 5'd20 : 5'd6))
            result7 = 7'h40;
        else if (tens_sel)
            result7 = (tens == 2'd0) ? 7'h00 : digit7({2'b00, tens});
        else
            result7 = digit7(ones[3:0]);
    endfunction

    assign step_wrap = step_q == STEP_LAST;

`ifdef DICE_DISPLAY_BLINK_EN
    logic [4:0] blink_q, blink_d;
    // 24 steps of blinking: bit 2 of the step count selects blank (0) or on (1) in 4-step halves
    assign blink_d = value_valid ? 5'd0 :
                     (state_q == SHOW && step_wrap && blink_q < 5'd24) ? blink_q + 5'd1 : blink_q;
    assign blank_d = state_d == SHOW && blink_d < 5'd24 && !blink_d[2];
`else
    assign blank_d = 1'b0;
`endif

    always_comb begin
        mux_d   = (mux_q == MUX_LAST) ? '0 : mux_q + 1'b1;
        dsel_d  = (mux_q == MUX_LAST) ? {dsel_q[0], dsel_q[1]} : dsel_q;
        state_d = state_q;
        step_d  = step_q;
        k_d     = k_q;
        n_d     = n_q;
        val_d   = val_q;
        mode_d  = mode_q;
        if (value_valid) begin
            state_d = SPIN;
            val_d   = dice_value;
            mode_d  = twty_mode;
            step_d  = '0;
            k_d     = '0;
            n_d     = '0;
        end else if (state_q != IDLE) begin
            step_d = step_wrap ? '0 : step_q + 1'b1;
            if (state_q == SPIN && step_wrap) begin
                k_d = (k_q == 3'd5) ? 3'd0 : k_q + 3'd1;
                n_d = n_q + 1'b1;
                state_d = (n_q == ANIM_LAST) ? SHOW : SPIN;
            end
        end
        seg_d = (state_d == IDLE || blank_d) ? 7'h00 :
                (state_d == SPIN) ? ((dsel_d[1] && !mode_d) ? 7'h00 : 7'(7'd1 << k_d)) :
                result7(val_d, mode_d, dsel_d[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mux_q   <= '0;
            step_q  <= '0;
            k_q     <= '0;
            n_q     <= '0;
            val_q   <= '0;
            mode_q  <= 1'b0;
            dsel_q  <= 2'b01;
            seg_q   <= '0;
            busy_q  <= 1'b0;
`ifdef DICE_DISPLAY_BLINK_EN
            blink_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            mux_q   <= mux_d;
            step_q  <= step_d;
            k_q     <= k_d;
            n_q     <= n_d;
            val_q   <= val_d;
            mode_q  <= mode_d;
            dsel_q  <= dsel_d;
            seg_q   <= seg_d;
            busy_q  <= state_d == SPIN;
`ifdef DICE_DISPLAY_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dsel_q;
    assign busy    = busy_q;
endmodule
